// File: rtl/axi_rd_arbiter_2_if.sv
// AXI4 read-only bundle (AR + R channels) shared by the upstream and downstream
// sides of axi_rd_arbiter_2; the downstream instance carries one extra ID bit.
interface axi_rd_arbiter_2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter_2.sv
// Two-to-one AXI4 read arbiter: round-robin AR grant into a registered AR stage,
// source tagged in the ID MSB, R beats steered back by that bit, bounded outstanding bursts.
module axi_rd_arbiter_2 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi_rd_arbiter_2_if.slave  s0_axi,
  axi_rd_arbiter_2_if.slave  s1_axi,
  axi_rd_arbiter_2_if.master m_axi
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE, AR_PEND} arState_e;

  arState_e              arState_q, arState_d;
  logic [ID_WIDTH:0]     arId_q, arId_d;
  logic [ADDR_WIDTH-1:0] arAddr_q, arAddr_d;
  logic [7:0]            arLen_q, arLen_d;
  logic [2:0]            arSize_q, arSize_d;
  logic [1:0]            arBurst_q, arBurst_d;
  logic [2:0]            arProt_q, arProt_d;
  logic                  prio_q, prio_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  regFree;
  logic                  capOk;
  logic                  winner;
  logic                  grant;
  logic                  retire;
  logic                  rSel;
  logic [DATA_WIDTH-1:0] rData;

  // Grant only when the AR register can take a new entry and a burst slot is free.
  always_comb begin
    regFree = (arState_q == AR_IDLE) | m_axi.arready;
    capOk   = count_q < MAX_CNT;
    winner  = (s0_axi.arvalid & s1_axi.arvalid) ? prio_q : s1_axi.arvalid;
    grant   = !rst & regFree & capOk & (s0_axi.arvalid | s1_axi.arvalid);
    retire  = m_axi.rvalid & m_axi.rready & m_axi.rlast;
  end

  assign s0_axi.arready = grant & !winner;
  assign s1_axi.arready = grant & winner;

  always_comb begin
    arState_d = arState_q;
    arId_d    = arId_q;
    arAddr_d  = arAddr_q;
    arLen_d   = arLen_q;
    arSize_d  = arSize_q;
    arBurst_d = arBurst_q;
    arProt_d  = arProt_q;
    prio_d    = prio_q;
    count_d   = count_q;

    if (grant) begin
      arState_d = AR_PEND;
      prio_d    = !winner;
      if (winner) begin
        arId_d    = {1'b1, s1_axi.arid};
        arAddr_d  = s1_axi.araddr;
        arLen_d   = s1_axi.arlen;
        arSize_d  = s1_axi.arsize;
        arBurst_d = s1_axi.arburst;
        arProt_d  = s1_axi.arprot;
      end else begin
        arId_d    = {1'b0, s0_axi.arid};
        arAddr_d  = s0_axi.araddr;
        arLen_d   = s0_axi.arlen;
        arSize_d  = s0_axi.arsize;
        arBurst_d = s0_axi.arburst;
        arProt_d  = s0_axi.arprot;
      end
    end else if (m_axi.arready) begin
      arState_d = AR_IDLE;
    end

    // A retire with nothing outstanding is illegal upstream; hold at zero rather than wrap.
    case ({grant, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = (count_q == '0) ? count_q : count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arState_q <= AR_IDLE;
      arId_q    <= '0;
      arAddr_q  <= '0;
      arLen_q   <= '0;
      arSize_q  <= '0;
      arBurst_q <= '0;
      arProt_q  <= '0;
      prio_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      arState_q <= arState_d;
      arId_q    <= arId_d;
      arAddr_q  <= arAddr_d;
      arLen_q   <= arLen_d;
      arSize_q  <= arSize_d;
      arBurst_q <= arBurst_d;
      arProt_q  <= arProt_d;
      prio_q    <= prio_d;
      count_q   <= count_d;
    end
  end

  assign m_axi.arvalid = (arState_q == AR_PEND);
  assign m_axi.arid    = arId_q;
  assign m_axi.araddr  = arAddr_q;
  assign m_axi.arlen   = arLen_q;
  assign m_axi.arsize  = arSize_q;
  assign m_axi.arburst = arBurst_q;
  assign m_axi.arprot  = arProt_q;

  // R beats are steered per beat by the tag bit; no storage on this path.
  assign rSel  = m_axi.rid[ID_WIDTH];
  assign rData = m_axi.rdata;

  assign s0_axi.rid    = m_axi.rid[ID_WIDTH-1:0];
  assign s0_axi.rdata  = rData;
  assign s0_axi.rresp  = m_axi.rresp;
  assign s0_axi.rlast  = m_axi.rlast;
  assign s0_axi.rvalid = m_axi.rvalid & !rSel;

  assign s1_axi.rid    = m_axi.rid[ID_WIDTH-1:0];
  assign s1_axi.rdata  = rData;
  assign s1_axi.rresp  = m_axi.rresp;
  assign s1_axi.rlast  = m_axi.rlast;
  assign s1_axi.rvalid = m_axi.rvalid & rSel;

  assign m_axi.rready  = rSel ? s1_axi.rready : s0_axi.rready;

  retireNeedsOutstanding: assert property (@(posedge clk) disable iff (rst)
    !(retire && (count_q == '0)));
endmodule

// File: tb/tb_axi_rd_arbiter_2.sv
// Randomised scoreboard bench for axi_rd_arbiter_2 with a transaction-level
// reference model of the arbitration rules and a downstream slave model.
module tb_axi_rd_arbiter_2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IW   = 8;
  localparam int MAXO = 2;

  typedef struct {
    logic          port;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [2:0]    prot;
  } arReq_t;

  typedef struct {
    logic          port;
    logic [IW-1:0] id;
    int            beatsLeft;
  } burst_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic clk;
  logic rst;

  axi_rd_arbiter_2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW))     s0If();
  axi_rd_arbiter_2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW))     s1If();
  axi_rd_arbiter_2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW + 1)) mIf();

  axi_rd_arbiter_2 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .s0_axi(s0If), .s1_axi(s1If), .m_axi(mIf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     checks = 0;
  int     errors = 0;
  int     pReq0, pReq1, pArready, pBeat, pRr0, pRr1;
  logic   rstDrv;
  logic   monitorOn;
  arReq_t upReq[2];
  logic   upValid[2];
  arReq_t modelReg;
  logic   modelPending;
  logic   modelPrio;
  int     modelCount;
  arReq_t arExpQ[$];
  burst_t slaveQ[$];
  beat_t  rExp0[$];
  beat_t  rExp1[$];
  logic   curValid;
  logic   curPort;
  int     curIdx;
  beat_t  curBeat;
  logic   expGrant;
  logic   expWin;
  logic   expRready;

  function automatic bit chance(int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setKnobs(input int r0, input int r1, input int ar, input int bt, input int rr0, input int rr1);
    pReq0 = r0; pReq1 = r1; pArready = ar; pBeat = bt; pRr0 = rr0; pRr1 = rr1;
  endtask

  task automatic newReq(input int n);
    upReq[n].port  = 1'(n);
    upReq[n].id    = IW'($urandom);
    upReq[n].addr  = AW'($urandom);
    upReq[n].len   = 8'($urandom_range(3, 0));
    upReq[n].size  = 3'($urandom_range(2, 0));
    upReq[n].burst = 2'($urandom_range(2, 0));
    upReq[n].prot  = 3'($urandom);
    upValid[n]     = 1'b1;
  endtask

  // Inputs for the coming cycle plus the model's prediction of what the DUT must do with them.
  task automatic applyStimulus;
    logic freeSlot;
    logic capOk;
    rst = rstDrv;
    if (!upValid[0] && chance(pReq0)) newReq(0);
    if (!upValid[1] && chance(pReq1)) newReq(1);
    s0If.arvalid = upValid[0];
    s0If.arid    = upReq[0].id;
    s0If.araddr  = upReq[0].addr;
    s0If.arlen   = upReq[0].len;
    s0If.arsize  = upReq[0].size;
    s0If.arburst = upReq[0].burst;
    s0If.arprot  = upReq[0].prot;
    s1If.arvalid = upValid[1];
    s1If.arid    = upReq[1].id;
    s1If.araddr  = upReq[1].addr;
    s1If.arlen   = upReq[1].len;
    s1If.arsize  = upReq[1].size;
    s1If.arburst = upReq[1].burst;
    s1If.arprot  = upReq[1].prot;
    mIf.arready  = !rstDrv && chance(pArready);
    s0If.rready  = chance(pRr0);
    s1If.rready  = chance(pRr1);

    if (rstDrv) begin
      curValid = 1'b0;
      slaveQ.delete();
      rExp0.delete();
      rExp1.delete();
    end else if (!curValid && slaveQ.size() > 0 && chance(pBeat)) begin
      curIdx       = int'($urandom_range(slaveQ.size() - 1, 0));
      curPort      = slaveQ[curIdx].port;
      curBeat.id   = slaveQ[curIdx].id;
      curBeat.data = DW'($urandom);
      curBeat.resp = 2'($urandom);
      curBeat.last = (slaveQ[curIdx].beatsLeft == 1);
      curValid     = 1'b1;
      if (curPort) rExp1.push_back(curBeat);
      else         rExp0.push_back(curBeat);
    end

    mIf.rvalid = curValid;
    if (curValid) begin
      mIf.rid   = {curPort, curBeat.id};
      mIf.rdata = curBeat.data;
      mIf.rresp = curBeat.resp;
      mIf.rlast = curBeat.last;
    end else begin
      mIf.rid   = (IW + 1)'($urandom);
      mIf.rdata = DW'($urandom);
      mIf.rresp = 2'($urandom);
      mIf.rlast = 1'($urandom);
    end

    freeSlot  = !modelPending || mIf.arready;
    capOk     = modelCount < MAXO;
    expWin    = (upValid[0] && upValid[1]) ? modelPrio : upValid[1];
    expGrant  = !rstDrv && freeSlot && capOk && (upValid[0] || upValid[1]);
    expRready = curPort ? s1If.rready : s0If.rready;
  endtask

  // Advance the reference model by the transfers that happened at this clock edge.
  task automatic updateModel;
    burst_t b;
    if (rst) begin
      modelPending = 1'b0;
      modelCount   = 0;
      modelPrio    = 1'b0;
      arExpQ.delete();
      return;
    end
    if (modelPending && mIf.arready) begin
      b.port      = modelReg.port;
      b.id        = modelReg.id;
      b.beatsLeft = int'(modelReg.len) + 1;
      slaveQ.push_back(b);
      modelPending = 1'b0;
    end
    if (curValid && expRready) begin
      slaveQ[curIdx].beatsLeft--;
      if (curBeat.last) begin
        slaveQ.delete(curIdx);
        modelCount--;
      end
      curValid = 1'b0;
    end
    if (expGrant) begin
      modelReg      = upReq[expWin];
      modelReg.port = expWin;
      arExpQ.push_back(modelReg);
      modelPending  = 1'b1;
      modelPrio     = !expWin;
      modelCount++;
      upValid[expWin] = 1'b0;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      updateModel();
      #1;
      applyStimulus();
    end
  endtask

  // Monitor: compares DUT outputs against predictions and pops the scoreboards on handshakes.
  task automatic checkCycle;
    arReq_t e;
    beat_t  b;
    checkOutput("s0_arready", 64'(s0If.arready), 64'(expGrant && !expWin));
    checkOutput("s1_arready", 64'(s1If.arready), 64'(expGrant && expWin));
    checkOutput("m_arvalid", 64'(mIf.arvalid), 64'(modelPending));
    if (mIf.arvalid && mIf.arready) begin
      checkOutput("ar_queue_depth", 64'(arExpQ.size()), 64'd1);
      if (arExpQ.size() > 0) begin
        e = arExpQ.pop_front();
        checkOutput("m_arid", 64'(mIf.arid), 64'({e.port, e.id}));
        checkOutput("m_araddr", 64'(mIf.araddr), 64'(e.addr));
        checkOutput("m_arlen", 64'(mIf.arlen), 64'(e.len));
        checkOutput("m_arsize", 64'(mIf.arsize), 64'(e.size));
        checkOutput("m_arburst", 64'(mIf.arburst), 64'(e.burst));
        checkOutput("m_arprot", 64'(mIf.arprot), 64'(e.prot));
      end
    end
    checkOutput("s0_rvalid", 64'(s0If.rvalid), 64'(curValid && !curPort));
    checkOutput("s1_rvalid", 64'(s1If.rvalid), 64'(curValid && curPort));
    if (curValid) checkOutput("m_rready", 64'(mIf.rready), 64'(expRready));
    if (s0If.rvalid && s0If.rready) begin
      checkOutput("r0_queue_depth", 64'(rExp0.size()), 64'd1);
      if (rExp0.size() > 0) begin
        b = rExp0.pop_front();
        checkOutput("s0_rid", 64'(s0If.rid), 64'(b.id));
        checkOutput("s0_rdata", 64'(s0If.rdata), 64'(b.data));
        checkOutput("s0_rresp", 64'(s0If.rresp), 64'(b.resp));
        checkOutput("s0_rlast", 64'(s0If.rlast), 64'(b.last));
      end
    end
    if (s1If.rvalid && s1If.rready) begin
      checkOutput("r1_queue_depth", 64'(rExp1.size()), 64'd1);
      if (rExp1.size() > 0) begin
        b = rExp1.pop_front();
        checkOutput("s1_rid", 64'(s1If.rid), 64'(b.id));
        checkOutput("s1_rdata", 64'(s1If.rdata), 64'(b.data));
        checkOutput("s1_rresp", 64'(s1If.rresp), 64'(b.resp));
        checkOutput("s1_rlast", 64'(s1If.rlast), 64'(b.last));
      end
    end
  endtask

  initial begin
    monitorOn = 1'b0;
    forever begin
      @(negedge clk);
      if (monitorOn) checkCycle();
    end
  end

  initial begin
    rstDrv       = 1'b1;
    upValid[0]   = 1'b0;
    upValid[1]   = 1'b0;
    modelPending = 1'b0;
    modelPrio    = 1'b0;
    modelCount   = 0;
    curValid     = 1'b0;
    curPort      = 1'b0;
    curIdx       = 0;
    curBeat.id   = '0;
    curBeat.data = '0;
    curBeat.resp = '0;
    curBeat.last = 1'b0;
    setKnobs(100, 100, 100, 0, 100, 100);
    applyStimulus();
    runCycles(3);

    // Both masters request during reset; nothing may be granted and the AR stage is cleared.
    @(negedge clk);
    checkOutput("rst_s0_arready", 64'(s0If.arready), 64'd0);
    checkOutput("rst_s1_arready", 64'(s1If.arready), 64'd0);
    checkOutput("rst_m_arvalid", 64'(mIf.arvalid), 64'd0);
    checkOutput("rst_m_araddr", 64'(mIf.araddr), 64'd0);
    checkOutput("rst_m_arid", 64'(mIf.arid), 64'd0);
    checkOutput("rst_m_arlen", 64'(mIf.arlen), 64'd0);
    rstDrv    = 1'b0;
    monitorOn = 1'b1;

    setKnobs(30, 0, 100, 60, 100, 100);
    runCycles(150);
    setKnobs(100, 100, 100, 80, 100, 100);
    runCycles(200);
    setKnobs(100, 100, 100, 0, 100, 100);
    runCycles(30);
    setKnobs(100, 100, 0, 80, 100, 100);
    runCycles(20);
    setKnobs(60, 60, 50, 80, 10, 100);
    runCycles(200);

    // Build a full outstanding count with one request stuck in the AR stage, then reset.
    setKnobs(0, 0, 100, 100, 100, 100);
    runCycles(40);
    setKnobs(100, 100, 100, 0, 100, 100);
    runCycles(2);
    setKnobs(100, 100, 0, 0, 100, 100);
    runCycles(3);
    rstDrv = 1'b1;
    runCycles(1);
    rstDrv = 1'b0;
    setKnobs(100, 100, 100, 80, 100, 100);
    runCycles(20);

    for (int k = 0; k < 20; k++) begin
      setKnobs(int'($urandom_range(100, 0)), int'($urandom_range(100, 0)),
               int'($urandom_range(100, 0)), int'($urandom_range(100, 10)),
               int'($urandom_range(100, 10)), int'($urandom_range(100, 10)));
      runCycles(50);
    end

    setKnobs(0, 0, 100, 100, 100, 100);
    runCycles(80);
    @(negedge clk);
    checkOutput("drain_ar_queue", 64'(arExpQ.size()), 64'd0);
    checkOutput("drain_r0_queue", 64'(rExp0.size()), 64'd0);
    checkOutput("drain_r1_queue", 64'(rExp1.size()), 64'd0);

    monitorOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
